lsu_ctrl: RTL and testbench



---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_fault_check.sv | 32 +++
 rtl/lsu_ctrl.sv | 126 ++++++++++++
 tb/tb_lsu_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store sequencer.
//   - Size codes as seen on req_size / mem_size.
//   - Response cause codes driven on rsp_cause.
//   - FSM state encoding for lsu_ctrl.
package lsu_pkg;

  // Access size codes; bit 2 selects zero extension for loads.
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // Response cause codes.
  localparam logic [1:0] CAUSE_OK       = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] CAUSE_MEMEXC   = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRead,
    StResp
  } lsu_state_e;

endpackage

// File: rtl/lsu_fault_check.sv
// lsu_fault_check: combinational alignment and range check for one access.
// Ports:
//   size         in  3   access size code
//   addr         in  32  byte address
//   misaligned   out 1   address not aligned for size, or size code unsupported
//   out_of_range out 1   addr >= MEM_BYTES
// Kept free of any sequencer state so the fetch path can reuse it.
module lsu_fault_check
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic [2:0]  size,
  input  logic [31:0] addr,
  output logic        misaligned,
  output logic        out_of_range
);

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_B, SZ_BU: misaligned = 1'b0;
      SZ_H, SZ_HU: misaligned = addr[0];
      SZ_W:        misaligned = (addr[1:0] != 2'b00);
      // 011, 110, 111 have no meaning; reject them like a misalignment.
      default:     misaligned = 1'b1;
    endcase
  end

  assign out_of_range = (addr >= 32'(MEM_BYTES));

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the execute stage and the memory block.
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake; req_ready high only in idle
//   req_wr, req_size,
//   req_addr, req_wdata       request fields, captured on the handshake
//   rsp_valid/rsp_ready       response handshake; response held until taken
//   rsp_rdata, rsp_cause      load result (0 for stores/faults) and cause code
//   mem_addr, mem_data_in,
//   mem_wr, mem_en, mem_size  memory request, driven from the captured request
//   mem_data_out              registered memory read data (1-cycle latency)
//   mem_exception             memory-side exception during the enabled cycle
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_cause,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_wr,
  output logic        mem_en,
  output logic [2:0]  mem_size,
  input  logic [31:0] mem_data_out,
  input  logic        mem_exception
);

  lsu_state_e  state_q;
  logic        wr_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  cause_q;

  logic misaligned;
  logic out_of_range;

  // Checks the raw request so a fault can be answered without touching memory.
  lsu_fault_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_fault_check (
    .size        (req_size),
    .addr        (req_addr),
    .misaligned  (misaligned),
    .out_of_range(out_of_range)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      size_q  <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      cause_q <= CAUSE_OK;
    end else begin
      unique case (state_q)
        StIdle: begin
          // req_ready is high in idle, so req_valid alone is the handshake.
          if (req_valid) begin
            wr_q    <= req_wr;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= 32'h0;
            if (misaligned) begin
              cause_q <= CAUSE_MISALIGN;
              state_q <= StResp;
            end else if (out_of_range) begin
              cause_q <= CAUSE_RANGE;
              state_q <= StResp;
            end else begin
              cause_q <= CAUSE_OK;
              state_q <= StAccess;
            end
          end
        end
        StAccess: begin
          if (mem_exception) begin
            cause_q <= CAUSE_MEMEXC;
            state_q <= StResp;
          end else if (wr_q) begin
            state_q <= StResp;
          end else begin
            state_q <= StRead;
          end
        end
        StRead: begin
          // Memory formats data_out from mem_addr/mem_size, still held here.
          rdata_q <= mem_data_out;
          state_q <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign rsp_rdata   = rdata_q;
  assign rsp_cause   = cause_q;
  assign mem_en      = (state_q == StAccess);
  assign mem_wr      = (state_q == StAccess) && wr_q;
  assign mem_addr    = addr_q;
  assign mem_size    = size_q;
  assign mem_data_in = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  localparam int unsigned MemBytes = 65536;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_cause;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_wr;
  logic        mem_en;
  logic [2:0]  mem_size;
  logic [31:0] mem_data_out;
  logic        mem_exception;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  lsu_ctrl #(
    .MEM_BYTES(MemBytes)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_size     (req_size),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_cause    (rsp_cause),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_wr       (mem_wr),
    .mem_en       (mem_en),
    .mem_size     (mem_size),
    .mem_data_out (mem_data_out),
    .mem_exception(mem_exception)
  );

  // ---------------- memory environment (the block the DUT drives) ----------------
  logic [7:0]  env_mem [MemBytes];
  logic [31:0] raw_q;
  logic        exc_inject;
  int          en_total = 0;

  assign mem_exception = exc_inject & mem_en;

  always @(posedge CLK) begin
    if (mem_en) en_total <= en_total + 1;
    if (mem_en && mem_wr) begin
      env_mem[mem_addr[15:0]] <= mem_data_in[7:0];
      if (mem_size[1:0] != 2'b00) env_mem[mem_addr[15:0] + 16'd1] <= mem_data_in[15:8];
      if (mem_size[1:0] == 2'b10) begin
        env_mem[mem_addr[15:0] + 16'd2] <= mem_data_in[23:16];
        env_mem[mem_addr[15:0] + 16'd3] <= mem_data_in[31:24];
      end
    end
    if (mem_en && !mem_wr) begin
      raw_q <= {env_mem[{mem_addr[15:2], 2'b11}], env_mem[{mem_addr[15:2], 2'b10}],
                env_mem[{mem_addr[15:2], 2'b01}], env_mem[{mem_addr[15:2], 2'b00}]};
    end
  end

  // Output formatting uses the live mem_addr / mem_size.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = raw_q[8*mem_addr[1:0] +: 8];
    h = raw_q[16*mem_addr[1] +: 16];
    mem_data_out = raw_q;
    case (mem_size)
      3'b000:  mem_data_out = {{24{b[7]}}, b};
      3'b100:  mem_data_out = {24'h0, b};
      3'b001:  mem_data_out = {{16{h[15]}}, h};
      3'b101:  mem_data_out = {16'h0, h};
      default: mem_data_out = raw_q;
    endcase
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [MemBytes];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outcome of one request from the architectural rules alone.
  task automatic ref_access(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic exc,
                            output logic [1:0] cause, output logic [31:0] rdata,
                            output int lat, output int ens);
    logic mis;
    int nb;
    logic [31:0] v;
    case (size)
      3'd0, 3'd4: mis = 1'b0;
      3'd1, 3'd5: mis = addr[0];
      3'd2:       mis = (addr[1:0] != 2'b00);
      default:    mis = 1'b1;
    endcase
    nb = 1 << size[1:0];
    rdata = 32'h0;
    if (mis) begin
      cause = 2'd1; lat = 1; ens = 0;
    end else if (addr >= MemBytes) begin
      cause = 2'd2; lat = 1; ens = 0;
    end else if (exc) begin
      cause = 2'd3; lat = 2; ens = 1;
    end else if (wr) begin
      for (int i = 0; i < nb; i++) ref_mem[16'(addr + 32'(i))] = wdata[8*i +: 8];
      cause = 2'd0; lat = 2; ens = 1;
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[16'(addr + 32'(i))];
      if (!size[2] && nb == 1) v = {{24{v[7]}}, v[7:0]};
      if (!size[2] && nb == 2) v = {{16{v[15]}}, v[15:0]};
      rdata = v;
      cause = 2'd0; lat = 3; ens = 1;
    end
  endtask

  // Issue one request, check latency/response/stability/handshake, then retire it.
  task automatic run_req(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold);
    logic [1:0]  e_cause;
    logic [31:0] e_rdata;
    logic [31:0] r0;
    int e_lat, e_ens, lat, k, en0;
    ref_access(wr, size, addr, wdata, exc_inject, e_cause, e_rdata, e_lat, e_ens);
    @(negedge CLK);
    req_valid = 1'b1; req_wr = wr; req_size = size; req_addr = addr; req_wdata = wdata;
    rsp_ready = (hold == 0);
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge CLK);
      k++;
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge CLK);
    #1;
    en0 = en_total;
    req_valid = 1'b0; req_wr = 1'($urandom); req_size = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      check("req_ready_busy", 32'(req_ready), 32'd0);
      @(posedge CLK);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(e_lat));
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_rdata", rsp_rdata, e_rdata);
    check("rsp_cause", 32'(rsp_cause), 32'(e_cause));
    check("req_ready_resp", 32'(req_ready), 32'd0);
    r0 = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK);
      #1;
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, r0);
      check("hold_cause", 32'(rsp_cause), 32'(e_cause));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge CLK);
    rsp_ready = 1'b1;
    @(posedge CLK);
    #1;
    rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("req_ready_after", 32'(req_ready), 32'd1);
    check("mem_en_cycles", 32'(en_total - en0), 32'(e_ens));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  sz;
    logic [31:0] a;
    logic        w;
    int          r;
    for (int i = 0; i < int'(MemBytes); i++) begin
      env_mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    raw_q = 32'h0;
    exc_inject = 1'b0;
    RST = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_cause", 32'(rsp_cause), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Store then load a word with rsp_ready held high.
    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
    // Byte store, signed and unsigned reload, whole word to see neighbours.
    run_req(1'b1, 3'b000, 32'h21, 32'h00000080, 0);
    run_req(1'b0, 3'b000, 32'h21, 32'h0, 0);
    run_req(1'b0, 3'b100, 32'h21, 32'h0, 0);
    run_req(1'b0, 3'b010, 32'h20, 32'h0, 0);
    // Misaligned requests leave memory alone.
    run_req(1'b0, 3'b001, 32'h3, 32'h0, 0);
    run_req(1'b1, 3'b010, 32'h6, 32'h12345678, 0);
    run_req(1'b0, 3'b010, 32'h4, 32'h0, 0);
    run_req(1'b0, 3'b010, 32'h8, 32'h0, 0);
    // Range boundary.
    run_req(1'b0, 3'b010, 32'h10000, 32'h0, 0);
    run_req(1'b0, 3'b010, 32'hFFFC, 32'h0, 0);
    // Misalignment outranks range.
    run_req(1'b0, 3'b010, 32'h10001, 32'h0, 0);
    // Back-pressure on the response.
    run_req(1'b0, 3'b010, 32'h10, 32'h0, 5);
    // Memory exception during the access cycle.
    exc_inject = 1'b1;
    run_req(1'b0, 3'b010, 32'h40, 32'h0, 1);
    exc_inject = 1'b0;

    // Reset pulse while the load is in its read cycle.
    @(negedge CLK);
    req_valid = 1'b1; req_wr = 1'b0; req_size = 3'b010; req_addr = 32'h10; rsp_ready = 1'b0;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_req_ready", 32'(req_ready), 32'd1);
    check("rstmid_mem_en", 32'(mem_en), 32'd0);
    @(posedge CLK);
    #1;
    check("rstmid_rsp_valid2", 32'(rsp_valid), 32'd0);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 200; n++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 7));
      if (w && (sz == 3'd4 || sz == 3'd5)) sz = sz - 3'd4;
      r = $urandom_range(0, 9);
      if (r < 7) a = 32'($urandom_range(0, 255));
      else if (r == 7) a = 32'hFFF0 + 32'($urandom_range(0, 31));
      else a = $urandom;
      run_req(w, sz, a, $urandom, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
